bit_cpt_n: RTL and testbench
============================

Name: bit_cpt_n

Overview:
- Parametrised successor to the fixed 3-bit counter: WIDTH-bit synchronous counter with programmable modulus, up/down direction, parallel load, and wrap or saturate mode.
- Exposes terminal-count and overflow flags so counters can be cascaded into wider or multi-digit counters.
- Sits in the compteur library as the general counter primitive; dividers, timers and sequencers instantiate it.

Parameters:
- WIDTH, 3, counter width in bits; legal range is 1 or more.
- MODULO, 8, number of count states; the counter spans 0..MODULO-1; legal range is 2 <= MODULO <= 2**WIDTH.
- SATURATE, 0, selects the end-of-range rule: 0 means wrap around, 1 means hold at the end of the range.

Ports:
- clk  input  1  clock; every state change happens on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- activate  input  1  count enable; the counter steps by one on a rising clk edge while this is 1.
- up_down  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value to load.
- cpt  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational): 1 when cpt==MODULO-1 and up_down=1, or when cpt==0 and up_down=0.
- overflow  output  1  registered pulse, one cycle wide, on each wrap or saturation hit.

Behaviour:
- Reset: reset=0 forces cpt=0 and overflow=0 immediately, with no dependence on clk.
  - While reset=0, clk edges are ignored.
  - The first counting edge after reset goes high acts normally, with no extra latency.
  - Reset asserted mid-count discards the current state; no partial update is allowed.
- Per rising clk edge, priority order is: load, then activate, then hold.
- load=1:
  - cpt <= load_value if load_value < MODULO, otherwise cpt <= MODULO-1 (clamp).
  - overflow <= 0.
  - activate is ignored on that edge.
- activate=1, up_down=1, with SATURATE=0 (wrap mode):
  - If cpt < MODULO-1: cpt <= cpt+1, overflow <= 0.
  - If cpt == MODULO-1: cpt <= 0, overflow <= 1.
- activate=1, up_down=0, wrap mode:
  - If cpt > 0: cpt <= cpt-1, overflow <= 0.
  - If cpt == 0: cpt <= MODULO-1, overflow <= 1.
- Saturate mode (SATURATE=1):
  - A step past the end of the range holds cpt and sets overflow <= 1 for that edge.
  - Repeated attempts at the end of the range pulse overflow on every such edge.
- Idle (activate=0, load=0): cpt holds and overflow <= 0. overflow therefore never stays high longer than one cycle without a new event.
- Latency:
  - cpt updates one edge after load or activate is sampled.
  - tc follows cpt and up_down combinationally with zero latency.
- Cascading: the next stage's activate is driven by this stage's activate & tc.
- Width rules:
  - All arithmetic is WIDTH bits wide; no intermediate result is wider than WIDTH+1 bits.
  - When MODULO == 2**WIDTH, natural binary wrap is allowed, but the compare against MODULO-1 must still be performed explicitly.
  - The register never holds a value of MODULO or above, including after a load.
- Changing up_down mid-count takes effect on the next edge with no glitch on cpt.
- Illegal parameters: if MODULO > 2**WIDTH or MODULO < 2, elaboration halts with an error.

Decomposition:
- Shared include cpt_defs.vh holds:
  - CPT_MODE_WRAP = 0 and CPT_MODE_SAT = 1;
  - the DIR_UP and DIR_DOWN encodings.
- Sub-module bit_cpt_cell: a one-bit register with asynchronous active-low clear, a load mux and a next-state input, generated WIDTH times.
- The modulus compare, clamp and flag logic live in the top level.

Test Plan:
- WIDTH=3, MODULO=5, wrap mode:
  - reset=0 for 2 cycles, then activate=1, up_down=1 for 7 edges -> cpt goes 1,2,3,4,0,1,2.
  - overflow=1 only in the cycle after 4->0.
  - tc=1 while cpt==4.
- Same configuration, up_down=0 starting from cpt=1 -> cpt goes 0,4,3.
  - overflow pulses on 0->4.
  - tc=1 while cpt==0.
- SATURATE=1, MODULO=5, counting up from 3 -> cpt goes 4,4,4.
  - overflow=1 on the second and third edges.
  - tc stays 1.
- load=1 with load_value=6, MODULO=5 -> cpt=4.
  - load and activate both 1 with load_value=2 -> cpt=2 (load wins).
- Pull reset low between clk edges while cpt=3 -> cpt=0 and overflow=0 before the next edge.
  - Release reset and count -> cpt=1 after the first edge.
- Cascade two instances (MODULO=10, decade counter):
  - 25 enabled edges -> low stage=5, high stage=2.
  - The high stage increments only on edges where the low stage has tc=1.

Source files
------------

// File: rtl/bit_cpt_n_pkg.sv
// Shared constants for the bit_cpt_n counter family: end-of-range modes and
// direction encodings.
package bit_cpt_n_pkg;

  localparam int CPT_MODE_WRAP = 0;
  localparam int CPT_MODE_SAT  = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cpt_dir_e;

endpackage

// File: rtl/bit_cpt_n_if.sv
// Control/status bundle between a bit_cpt_n counter and whatever drives it.
interface bit_cpt_n_if #(
  parameter int WIDTH = 3
) ();

  logic             activate;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] cpt;
  logic             tc;
  logic             overflow;

  modport master (
    output activate, up_down, load, load_value,
    input  cpt, tc, overflow
  );

  modport slave (
    input  activate, up_down, load, load_value,
    output cpt, tc, overflow
  );

endinterface

// File: rtl/bit_cpt_n_cell.sv
// One counter bit: async active-low clear, load mux over a next-state input.
module bit_cpt_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic load_bit_i,
  input  logic next_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= load_i ? load_bit_i : next_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bit_cpt_n.sv
// WIDTH-bit modulo-MODULO up/down counter with clamped parallel load,
// wrap or saturate end-of-range rule, terminal-count and overflow flags.
module bit_cpt_n
  import bit_cpt_n_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 8,
  parameter int SATURATE = CPT_MODE_WRAP
) (
  input  logic      clk,
  input  logic      reset,
  bit_cpt_n_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 62 || MODULO < 2 ||
      longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_param
    $error("bit_cpt_n: illegal WIDTH/MODULO combination");
  end

  localparam logic [WIDTH-1:0] CPT_MAX  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   CPT_MOD  = (WIDTH+1)'(MODULO);
  localparam bit               SAT_MODE = (SATURATE != CPT_MODE_WRAP);

  logic [WIDTH-1:0] cpt_q;
  logic [WIDTH-1:0] cpt_d;
  logic [WIDTH-1:0] load_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             at_max;
  logic             at_zero;
  cpt_dir_e         dir;

  assign dir     = cpt_dir_e'(bus.up_down);
  assign at_max  = (cpt_q == CPT_MAX);
  assign at_zero = (cpt_q == '0);

  // End-of-range is compared explicitly even when MODULO == 2**WIDTH.
  always_comb begin
    load_d     = ({1'b0, bus.load_value} < CPT_MOD) ? bus.load_value : CPT_MAX;
    cpt_d      = cpt_q;
    overflow_d = 1'b0;
    if (!bus.load && bus.activate) begin
      if (dir == DIR_UP) begin
        overflow_d = at_max;
        if (!at_max)       cpt_d = cpt_q + WIDTH'(1);
        else if (!SAT_MODE) cpt_d = '0;
      end else begin
        overflow_d = at_zero;
        if (!at_zero)      cpt_d = cpt_q - WIDTH'(1);
        else if (!SAT_MODE) cpt_d = CPT_MAX;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bit_cpt_cell u_cell (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (bus.load),
      .load_bit_i (load_d[i]),
      .next_i     (cpt_d[i]),
      .q_o        (cpt_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.cpt      = cpt_q;
  assign bus.overflow = overflow_q;
  assign bus.tc       = (dir == DIR_UP) ? at_max : at_zero;

endmodule

// File: tb/tb_bit_cpt_n.sv
// Directed bench for bit_cpt_n: wrap, saturate, load clamp, async reset, and a
// two-stage decade cascade.
module tb_bit_cpt_n;

  logic clk = 1'b0;
  logic rst_n;
  logic c_en;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bit_cpt_n_if #(.WIDTH(3)) w_if ();
  bit_cpt_n_if #(.WIDTH(3)) s_if ();
  bit_cpt_n_if #(.WIDTH(4)) lo_if ();
  bit_cpt_n_if #(.WIDTH(4)) hi_if ();

  bit_cpt_n #(.WIDTH(3), .MODULO(5), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(rst_n), .bus(w_if.slave));
  bit_cpt_n #(.WIDTH(3), .MODULO(5), .SATURATE(1)) u_sat (
    .clk(clk), .reset(rst_n), .bus(s_if.slave));
  bit_cpt_n #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_lo (
    .clk(clk), .reset(rst_n), .bus(lo_if.slave));
  bit_cpt_n #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_hi (
    .clk(clk), .reset(rst_n), .bus(hi_if.slave));

  assign lo_if.activate = c_en;
  assign hi_if.activate = c_en & lo_if.tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_up[7];
    int exp_dn[3];
    int exp_dn_ov[3];
    int exp_dn_tc[3];
    int lo_m;
    int hi_m;
    bit hi_inc;

    exp_up    = '{1, 2, 3, 4, 0, 1, 2};
    exp_dn    = '{0, 4, 3};
    exp_dn_ov = '{0, 1, 0};
    exp_dn_tc = '{1, 0, 0};

    rst_n = 1'b0;
    c_en  = 1'b0;
    w_if.activate = 1'b0; w_if.up_down = 1'b1; w_if.load = 1'b0; w_if.load_value = '0;
    s_if.activate = 1'b0; s_if.up_down = 1'b1; s_if.load = 1'b0; s_if.load_value = '0;
    lo_if.up_down = 1'b1; lo_if.load = 1'b0; lo_if.load_value = '0;
    hi_if.up_down = 1'b1; hi_if.load = 1'b0; hi_if.load_value = '0;

    #1;
    check("reset_cpt", 32'(w_if.cpt), 0);
    check("reset_ovf", 32'(w_if.overflow), 0);

    // Edges during reset are ignored even with activate high.
    w_if.activate = 1'b1;
    tick();
    tick();
    check("reset_hold_cpt", 32'(w_if.cpt), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("up_cpt[%0d]", i), 32'(w_if.cpt), 32'(exp_up[i]));
      check($sformatf("up_ovf[%0d]", i), 32'(w_if.overflow), (i == 4) ? 1 : 0);
      check($sformatf("up_tc[%0d]", i), 32'(w_if.tc), (exp_up[i] == 4) ? 1 : 0);
    end

    w_if.activate = 1'b0;
    w_if.load = 1'b1; w_if.load_value = 3'd1;
    tick();
    check("load1_cpt", 32'(w_if.cpt), 1);
    w_if.load = 1'b0;
    w_if.up_down = 1'b0;
    #1;
    check("dn_tc_at1", 32'(w_if.tc), 0);
    w_if.activate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("dn_cpt[%0d]", i), 32'(w_if.cpt), 32'(exp_dn[i]));
      check($sformatf("dn_ovf[%0d]", i), 32'(w_if.overflow), 32'(exp_dn_ov[i]));
      check($sformatf("dn_tc[%0d]", i), 32'(w_if.tc), 32'(exp_dn_tc[i]));
    end

    w_if.activate = 1'b0;
    tick();
    check("idle_cpt", 32'(w_if.cpt), 3);
    check("idle_ovf", 32'(w_if.overflow), 0);

    w_if.load = 1'b1; w_if.load_value = 3'd6;
    tick();
    check("clamp_cpt", 32'(w_if.cpt), 4);
    w_if.load_value = 3'd2; w_if.activate = 1'b1; w_if.up_down = 1'b1;
    tick();
    check("load_wins_cpt", 32'(w_if.cpt), 2);
    check("load_wins_ovf", 32'(w_if.overflow), 0);

    w_if.activate = 1'b0; w_if.load_value = 3'd3;
    s_if.load = 1'b1; s_if.load_value = 3'd3;
    tick();
    w_if.load = 1'b0;
    s_if.load = 1'b0; s_if.activate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_cpt[%0d]", i), 32'(s_if.cpt), 4);
      check($sformatf("sat_ovf[%0d]", i), 32'(s_if.overflow), (i > 0) ? 1 : 0);
      check($sformatf("sat_tc[%0d]", i), 32'(s_if.tc), 1);
    end
    check("pre_rst_cpt", 32'(w_if.cpt), 3);

    // Reset pulled low between edges must clear state immediately.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_cpt", 32'(w_if.cpt), 0);
    check("async_rst_ovf", 32'(w_if.overflow), 0);
    check("async_rst_sat_cpt", 32'(s_if.cpt), 0);
    check("async_rst_sat_ovf", 32'(s_if.overflow), 0);
    s_if.activate = 1'b0;
    w_if.activate = 1'b1; w_if.up_down = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_cpt", 32'(w_if.cpt), 1);
    w_if.activate = 1'b0;

    lo_m = 0;
    hi_m = 0;
    c_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      hi_inc = (lo_m == 9);
      lo_m = (lo_m + 1) % 10;
      if (hi_inc) hi_m = (hi_m + 1) % 10;
      tick();
      check($sformatf("casc_lo[%0d]", i), 32'(lo_if.cpt), 32'(lo_m));
      check($sformatf("casc_hi[%0d]", i), 32'(hi_if.cpt), 32'(hi_m));
    end
    c_en = 1'b0;
    check("casc_lo_final", 32'(lo_if.cpt), 5);
    check("casc_hi_final", 32'(hi_if.cpt), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
